// File: rtl/increment_time.sv
// BCD MM:SS timekeeper with sanitising load, one-second increment and max detection.
// Optional macro INCREMENT_TIME_SATURATE_EN: hold at maximum instead of wrapping to 00:00.
module increment_time #(
  parameter logic [7:0] MAX_MIN = 8'h99
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        loadEnable,
  input  logic [15:0] loadTime,
  input  logic        incEnable,
  output logic [15:0] outputTime,
  output logic        isMax,
  output logic        rollover
);

  localparam logic [15:0] MAX_TIME = {MAX_MIN, 8'h59};

  logic [15:0] time_q, time_d;
  logic        is_max_q, is_max_d;
  logic        rollover_q, rollover_d;

  logic [3:0]  ld_mt, ld_mo, ld_st, ld_so;
  logic [15:0] load_val;
  logic [3:0]  in_mt, in_mo, in_st, in_so;
  logic [15:0] inc_val;
  logic        at_max;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Load path: clamp each digit, then clamp the whole value to the ceiling.
  // Valid BCD compares correctly as plain binary.
  always_comb begin
    ld_mt    = clamp_digit(loadTime[15:12], 4'd9);
    ld_mo    = clamp_digit(loadTime[11:8],  4'd9);
    ld_st    = clamp_digit(loadTime[7:4],   4'd5);
    ld_so    = clamp_digit(loadTime[3:0],   4'd9);
    load_val = {ld_mt, ld_mo, ld_st, ld_so};
    if ({ld_mt, ld_mo} > MAX_MIN) begin
      load_val = MAX_TIME;
    end
  end

  // Increment path: BCD ripple carry through the four digits.
  always_comb begin
    in_mt = time_q[15:12];
    in_mo = time_q[11:8];
    in_st = time_q[7:4];
    in_so = time_q[3:0];
    if (in_so < 4'd9) begin
      in_so = in_so + 4'd1;
    end else begin
      in_so = 4'd0;
      if (in_st < 4'd5) begin
        in_st = in_st + 4'd1;
      end else begin
        in_st = 4'd0;
        if (in_mo < 4'd9) begin
          in_mo = in_mo + 4'd1;
        end else begin
          in_mo = 4'd0;
          in_mt = (in_mt < 4'd9) ? (in_mt + 4'd1) : 4'd0;
        end
      end
    end
    inc_val = {in_mt, in_mo, in_st, in_so};
  end

  assign at_max = (time_q == MAX_TIME);

  always_comb begin
    time_d     = time_q;
    rollover_d = 1'b0;
    if (loadEnable) begin
      time_d = load_val;
    end else if (incEnable) begin
      if (at_max) begin
`ifdef INCREMENT_TIME_SATURATE_EN
        time_d = MAX_TIME;
`else
        time_d = 16'h0000;
`endif
        rollover_d = 1'b1;
      end else begin
        time_d = inc_val;
      end
    end
    // Derived from the next state so the flag lines up with outputTime.
    is_max_d = (time_d == MAX_TIME);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q     <= 16'h0000;
      is_max_q   <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      time_q     <= time_d;
      is_max_q   <= is_max_d;
      rollover_q <= rollover_d;
    end
  end

  assign outputTime = time_q;
  assign isMax      = is_max_q;
  assign rollover   = rollover_q;

endmodule

// File: tb/tb_increment_time.sv
// Directed-vector bench for increment_time: reset, load clamping, carries, max handling, long sweep.
module tb_increment_time;

  logic        clk;
  logic        reset;
  logic        loadEnable;
  logic [15:0] loadTime;
  logic        incEnable;
  logic [15:0] outputTime;
  logic        isMax;
  logic        rollover;

  int n_vec;
  int n_err;

  increment_time #(.MAX_MIN(8'h99)) dut (
    .clk        (clk),
    .reset      (reset),
    .loadEnable (loadEnable),
    .loadTime   (loadTime),
    .incEnable  (incEnable),
    .outputTime (outputTime),
    .isMax      (isMax),
    .rollover   (rollover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp, input bit quiet = 1'b0);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else if (!quiet) begin
      $display("vec %0d %s: %h ok", n_vec, tag, obs);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the active edge.
  task automatic step(input logic le, input logic [15:0] lt, input logic ie);
    @(negedge clk);
    loadEnable = le;
    loadTime   = lt;
    incEnable  = ie;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] secs_to_bcd(input int t);
    int m, s;
    logic [3:0] d3, d2, d1, d0;
    m  = t / 60;
    s  = t % 60;
    d3 = 4'(m / 10);
    d2 = 4'(m % 10);
    d1 = 4'(s / 10);
    d0 = 4'(s % 10);
    return {d3, d2, d1, d0};
  endfunction

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    loadEnable = 1'b0;
    loadTime   = 16'h0000;
    incEnable  = 1'b0;

    #3;
    check("reset_time", outputTime, 16'h0000);
    check("reset_max",  {15'd0, isMax}, 16'h0000);
    check("reset_roll", {15'd0, rollover}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Seconds and minute carries
    step(1'b1, 16'h0958, 1'b0);
    check("load_0958", outputTime, 16'h0958);
    step(1'b0, 16'h0000, 1'b1);
    check("inc_0959", outputTime, 16'h0959);
    check("inc_0959_roll", {15'd0, rollover}, 16'h0000);
    step(1'b0, 16'h0000, 1'b1);
    check("inc_1000", outputTime, 16'h1000);
    check("inc_1000_roll", {15'd0, rollover}, 16'h0000);
    step(1'b0, 16'h0000, 1'b0);
    check("idle_hold", outputTime, 16'h1000);

    step(1'b1, 16'h1FA7, 1'b0);
    check("load_clamp", outputTime, 16'h1957);
    step(1'b1, 16'hFFFF, 1'b0);
    check("load_all_f", outputTime, 16'h9959);
    check("load_all_f_max", {15'd0, isMax}, 16'h0001);
    check("load_roll", {15'd0, rollover}, 16'h0000);

    // Increment at maximum
    step(1'b1, 16'h9959, 1'b0);
    check("load_max_ismax", {15'd0, isMax}, 16'h0001);
    step(1'b0, 16'h0000, 1'b1);
`ifdef INCREMENT_TIME_SATURATE_EN
    check("max_inc_time", outputTime, 16'h9959);
    check("max_inc_ismax", {15'd0, isMax}, 16'h0001);
`else
    check("max_inc_time", outputTime, 16'h0000);
    check("max_inc_ismax", {15'd0, isMax}, 16'h0000);
`endif
    check("max_inc_roll", {15'd0, rollover}, 16'h0001);
    step(1'b0, 16'h0000, 1'b1);
`ifdef INCREMENT_TIME_SATURATE_EN
    check("max_inc2_time", outputTime, 16'h9959);
    check("max_inc2_roll", {15'd0, rollover}, 16'h0001);
`else
    check("after_wrap_time", outputTime, 16'h0001);
    check("after_wrap_roll", {15'd0, rollover}, 16'h0000);
`endif
    step(1'b0, 16'h0000, 1'b0);
    check("idle_roll", {15'd0, rollover}, 16'h0000);

    // Load wins over increment
    step(1'b1, 16'h0305, 1'b1);
    check("load_prio", outputTime, 16'h0305);
    check("load_prio_roll", {15'd0, rollover}, 16'h0000);

    // Asynchronous reset between edges while rollover is high
    step(1'b1, 16'h9959, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    check("pre_reset_roll", {15'd0, rollover}, 16'h0001);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_time", outputTime, 16'h0000);
    check("async_rst_roll", {15'd0, rollover}, 16'h0000);
    check("async_rst_max",  {15'd0, isMax}, 16'h0000);
    step(1'b1, 16'h1234, 1'b1);
    check("rst_ignores_in", outputTime, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 16'h1234, 1'b0);
    check("first_after_rst", outputTime, 16'h1234);

    // One-hour sweep against an integer seconds model
    step(1'b1, 16'h0000, 1'b0);
    check("sweep_start", outputTime, 16'h0000);
    for (int i = 1; i <= 3600; i++) begin
      step(1'b0, 16'h0000, 1'b1);
      check($sformatf("sweep_%0d", i), outputTime, secs_to_bcd(i), 1'b1);
    end
    $display("sweep of 3600 increments done, now %h", outputTime);
    check("sweep_end", outputTime, 16'h6000);
    check("sweep_end_roll", {15'd0, rollover}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/increment_time.md
INCREMENT_TIME -- requirements
Module: increment_time

Interface
REQ-001 SHALL provide parameter MAX_MIN, default 8'h99, meaning BCD minute ceiling (legal 8'h00..8'h99).
REQ-002 SHALL provide port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-003 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL provide port loadEnable, input, 1, load loadTime this cycle.
REQ-005 SHALL provide port loadTime, input, 16, BCD MM:SS preset, with [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
REQ-006 SHALL provide port incEnable, input, 1, advance time by one second this cycle.
REQ-007 SHALL provide port outputTime, output, 16, registered BCD MM:SS in the same layout as loadTime.
REQ-008 SHALL provide port isMax, output, 1, level high while outputTime == {MAX_MIN,8'h59}.
REQ-009 SHALL provide port rollover, output, 1, one-cycle pulse when the count wraps or saturates at maximum.

Function
REQ-010 SHALL update outputTime one cycle after a sampled loadEnable or incEnable; with neither asserted, outputTime SHALL hold.
REQ-011 SHALL give loadEnable priority over incEnable when both are high; the increment is discarded.
REQ-012 SHALL sanitise on load: sec ones >9 -> 9; sec tens >5 -> 5; min ones >9 -> 9; min tens >9 -> 9; then, if the minute value exceeds MAX_MIN, load {MAX_MIN,8'h59}.
REQ-013 SHALL increment sec ones by 1 when sec ones < 9.
REQ-014 SHALL, at sec ones == 9, set sec ones to 0 and increment sec tens.
REQ-015 SHALL, at seconds == 8'h59, set seconds to 8'h00 and increment minutes in BCD: min ones 9 -> 0 with carry into min tens.
REQ-016 SHALL treat incEnable at outputTime == {MAX_MIN,8'h59} per REQ-025/REQ-026 and assert rollover for exactly that cycle.
REQ-017 SHALL never present a non-BCD digit or seconds > 59 on outputTime.
REQ-018 SHALL register isMax, recomputing it from the next-state value so that it is coincident with outputTime.
REQ-019 SHALL keep rollover low on load cycles and on idle cycles.
REQ-020 SHALL NOT assert rollover on consecutive incEnable cycles unless each cycle individually meets the REQ-016 condition.

Reset
REQ-021 SHALL, on reset high, immediately (without waiting for clk) drive outputTime = 16'h0000, isMax = 0 and rollover = 0.
REQ-022 SHALL ignore loadEnable and incEnable while reset is high; the first update occurs on the first posedge after deassertion.
REQ-023 SHALL abort any in-progress carry when reset asserts mid-operation; no partial value SHALL be retained.

Configuration
REQ-024 SHALL honour macro INCREMENT_TIME_SATURATE_EN.
REQ-025 SHALL, with INCREMENT_TIME_SATURATE_EN defined, hold outputTime at {MAX_MIN,8'h59} on increment at maximum, with rollover pulsing and isMax remaining 1.
REQ-026 SHALL, without INCREMENT_TIME_SATURATE_EN, wrap outputTime to 16'h0000 on increment at maximum, pulse rollover and clear isMax.

Verification
REQ-027 SHALL cover: reset asserted between clock edges -> outputTime 16'h0000 before the next posedge, rollover 0.
REQ-028 SHALL cover: load 16'h0958, then 2 incEnable cycles -> 16'h0959, then 16'h1000; rollover stays 0.
REQ-029 SHALL cover: load 16'h1FA7 -> 16'h1957 (clamped digits).
REQ-030 SHALL cover: MAX_MIN = 8'h99, load 16'h9959, then incEnable -> 16'h0000, rollover = 1 for one cycle, isMax 1 -> 0 (macro off); 16'h9959 held with isMax = 1 (macro on).
REQ-031 SHALL cover: loadEnable and incEnable both high with loadTime 16'h0305 -> outputTime 16'h0305 (not 16'h0306).
REQ-032 SHALL cover: 3600 consecutive incEnable cycles from 16'h0000 -> 16'h6000, every intermediate value valid BCD with seconds <= 59.
